// File: rtl/mod6.sv
// Modulo-6 BCD down-counter: tens-of-seconds digit of the countdown timer.
// Clear beats load beats decrement; tc borrows into the next-higher digit.
module mod6 #(
  parameter int MODULUS = 6,
  parameter int WIDTH   = 4
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [WIDTH-1:0] data,
  input  logic             loadn,
  input  logic             en,
  output logic [WIDTH-1:0] ones,
  output logic             tc,
  output logic             zero
);

  localparam logic [WIDTH-1:0] C_WRAP = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] C_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Out-of-range load values saturate to the wrap value so the digit stays legal.
  function automatic logic [WIDTH-1:0] clamp_digit(input logic [WIDTH-1:0] value);
    if (value > C_WRAP) begin
      return C_WRAP;
    end else begin
      return value;
    end
  endfunction

  logic [WIDTH-1:0] r_ones;
  logic [WIDTH-1:0] w_next;
  logic             w_load;
  logic             w_dec;
  logic             w_zero;

  assign w_zero = (r_ones == C_ZERO);

  // Load/decrement qualifiers; an unknown loadn falls to the not-asserted side.
  always_comb begin
    w_load = 1'b0;
    w_dec  = 1'b0;
    if (clrn) begin
      w_load = 1'b0;
      w_dec  = 1'b0;
    end else if (loadn == 1'b0) begin
      w_load = 1'b1;
      w_dec  = 1'b0;
    end else begin
      w_load = 1'b0;
      w_dec  = en;
    end
  end

  // Next digit value for the non-clear cases.
  always_comb begin
    w_next = r_ones;
    if (w_load) begin
      w_next = clamp_digit(data);
    end else if (w_dec) begin
      if (w_zero) begin
        w_next = C_WRAP;
      end else begin
        w_next = r_ones - C_ONE;
      end
    end else begin
      w_next = r_ones;
    end
  end

  // Digit register; clear is synchronous and takes priority over everything.
  always_ff @(posedge clk) begin
    if (clrn) begin
      r_ones <= C_ZERO;
    end else begin
      r_ones <= w_next;
    end
  end

  assign ones = r_ones;
  assign zero = w_zero;
  assign tc   = w_dec & w_zero;

endmodule

// File: tb/tb_mod6.sv
// Directed bench for mod6: a modular-arithmetic reference model checked on every
// negedge, plus literal expectations pinning the model at each scenario.
module tb_mod6;

  logic       clk;
  logic       clrn;
  logic [3:0] data;
  logic       loadn;
  logic       en;
  logic [3:0] ones;
  logic       tc;
  logic       zero;

  int n_tests;
  int n_fail;

  int m_ones;
  bit m_valid;

  mod6 #(.MODULUS(6), .WIDTH(4)) dut (
    .clk  (clk),
    .clrn (clrn),
    .data (data),
    .loadn(loadn),
    .en   (en),
    .ones (ones),
    .tc   (tc),
    .zero (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference digit: clear to 0, saturating load, otherwise count down modulo 6.
  always @(posedge clk) begin
    if (clrn) begin
      m_ones  <= 0;
      m_valid <= 1'b1;
    end else if (!loadn) begin
      m_ones  <= (int'(data) > 5) ? 5 : int'(data);
      m_valid <= 1'b1;
    end else if (en) begin
      m_ones  <= (m_ones + 5) % 6;
    end
  end

  // Cycle-by-cycle comparison once the model is defined.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_ones", int'(ones), m_ones);
      check("model_zero", int'(zero), (m_ones == 0) ? 1 : 0);
      check("model_tc", int'(tc), (en && !clrn && loadn && m_ones == 0) ? 1 : 0);
    end
  end

  task automatic step(input logic c, input logic l, input logic e, input logic [3:0] d);
    clrn  = c;
    loadn = l;
    en    = e;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_seq [7];
    n_tests = 0;
    n_fail  = 0;
    m_valid = 1'b0;
    m_ones  = 0;
    clrn = 1'b0; loadn = 1'b1; en = 1'b0; data = 4'd0;
    #1;

    // Reset state
    step(1'b1, 1'b1, 1'b0, 4'd0);
    check("reset_ones", int'(ones), 0);
    check("reset_zero", int'(zero), 1);

    // Load 5 and count through the wrap
    step(1'b0, 1'b0, 1'b1, 4'd5);
    check("load5", int'(ones), 5);
    exp_seq = '{4, 3, 2, 1, 0, 5, 4};
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, 1'b1, 4'd0);
      check("count_seq", int'(ones), exp_seq[i]);
      if (exp_seq[i] == 0) begin
        check("count_tc_at_zero", int'(tc), 1);
        check("count_zero_flag", int'(zero), 1);
      end else begin
        check("count_tc_nonzero", int'(tc), 0);
      end
    end

    // Enable hold at 3
    step(1'b0, 1'b1, 1'b1, 4'd0);
    check("to3", int'(ones), 3);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'd0);
      check("hold_ones", int'(ones), 3);
      check("hold_tc", int'(tc), 0);
      check("hold_zero", int'(zero), 0);
    end
    step(1'b0, 1'b1, 1'b1, 4'd0);
    check("reenable", int'(ones), 2);

    // Clear beats load and enable
    step(1'b0, 1'b0, 1'b0, 4'd4);
    check("load4", int'(ones), 4);
    clrn = 1'b1; loadn = 1'b0; en = 1'b1; data = 4'd2;
    #1;
    check("tc_suppressed_clr", int'(tc), 0);
    @(posedge clk);
    #1;
    check("clr_prio_ones", int'(ones), 0);
    check("clr_prio_zero", int'(zero), 1);
    clrn = 1'b0; loadn = 1'b1; en = 1'b1; data = 4'd0;
    #1;
    check("tc_after_clr", int'(tc), 1);
    @(posedge clk);
    #1;
    check("wrap_after_clr", int'(ones), 5);

    // Load clamp
    step(1'b0, 1'b0, 1'b0, 4'd9);
    check("clamp9", int'(ones), 5);
    step(1'b0, 1'b0, 1'b0, 4'd0);
    check("load0", int'(ones), 0);
    check("load0_zero", int'(zero), 1);
    step(1'b0, 1'b0, 1'b0, 4'd15);
    check("clamp15", int'(ones), 5);
    step(1'b0, 1'b0, 1'b0, 4'd6);
    check("clamp6", int'(ones), 5);

    // Load over enable, including from zero where tc must stay low
    step(1'b0, 1'b0, 1'b0, 4'd1);
    check("load1", int'(ones), 1);
    step(1'b0, 1'b0, 1'b1, 4'd3);
    check("load_over_en", int'(ones), 3);
    step(1'b0, 1'b0, 1'b0, 4'd0);
    clrn = 1'b0; loadn = 1'b0; en = 1'b1; data = 4'd3;
    #1;
    check("tc_suppressed_load", int'(tc), 0);
    @(posedge clk);
    #1;
    check("load_from_zero", int'(ones), 3);

    // tc follows en combinationally while ones = 0
    step(1'b1, 1'b1, 1'b0, 4'd0);
    clrn = 1'b0; loadn = 1'b1; en = 1'b0;
    #1;
    check("tc_comb_low", int'(tc), 0);
    en = 1'b1;
    #1;
    check("tc_comb_high", int'(tc), 1);
    en = 1'b0;
    #1;
    check("tc_comb_low2", int'(tc), 0);
    @(posedge clk);
    #1;
    check("tc_comb_held", int'(ones), 0);

    // Mixed traffic checked by the model
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1,
           1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)));
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mod6.md
Name: mod6

Overview:
- Single-digit modulo-6 down-counter (BCD values 0–5): the tens-of-seconds digit of the microwave countdown timer.
- Loads a start value, decrements once per enabled clock, and wraps 0→5.
- Emits a terminal-count (borrow) pulse to chain to the next-higher digit, plus a zero flag for timer-done detection.

Parameters:
- MODULUS, 6, count range is 0..MODULUS-1; wrap value is MODULUS-1 = 5.
- WIDTH, 4, width of data and ones; BCD nibble.

Ports:
- clk  input  1  rising-edge clock; all state changes on posedge.
- clrn  input  1  synchronous clear, active-high despite the codebase name; forces count to 0.
- data  input  4  parallel load value (BCD).
- loadn  input  1  synchronous load, active-low.
- en  input  1  count enable (decrement request, typically a borrow from the lower digit).
- ones  output  4  current digit value, registered.
- tc  output  1  terminal count / borrow out, combinational.
- zero  output  1  high when ones == 0, combinational from the register.

Behaviour:
- Priority at each posedge clk: clrn > loadn > en > hold.
- clrn = 1: ones ← 0 next edge, regardless of loadn, en and data.
- clrn = 0, loadn = 0: ones ← data when data ≤ 5. Data 6..15 is clamped: ones ← 5. Load ignores en.
- clrn = 0, loadn = 1, en = 1:
  - ones > 0: ones ← ones − 1.
  - ones = 0: ones ← 5 (wrap).
- clrn = 0, loadn = 1, en = 0: ones holds.
- loadn = X/Z is treated as not asserted (hold/count); the implementation must not propagate X into ones when loadn is unknown but clrn = 1.
- tc = en AND (ones == 0). Purely combinational, no register delay; asserted in exactly the cycle whose next edge wraps 0→5.
- tc is suppressed (0) while clrn = 1 or loadn = 0, since no decrement occurs.
- zero = (ones == 0), independent of en.
- Reset state (after a clrn edge): ones = 0, zero = 1, tc = en.
- Power-up before any clear or load: ones is undefined. The system must clear or load first; the bench applies clrn or loadn before checking.
- Latency:
  - Load/clear/decrement visible on ones one clock after the sampling edge.
  - tc and zero follow ones combinationally, same cycle.
- ones never holds a value > 5 after any clear or load.
- Clear mid-count: takes effect at the next edge, even if en = 1 that cycle; no wrap, no tc.

Test Plan:
- Load and count: clrn = 0, data = 5, loadn = 0 for one edge, then loadn = 1, en = 1 → ones sequence 5,4,3,2,1,0,5,4…. tc = 1 only while ones = 0; zero = 1 only while ones = 0.
- Enable hold: from ones = 3, set en = 0 for 4 clocks → ones stays 3, tc = 0, zero = 0. Re-enable → ones = 2 on the next edge.
- Clear priority: ones = 4, en = 1, loadn = 0, data = 2, clrn = 1 at one edge → ones = 0, zero = 1. Releasing clrn with en = 1 → next edge ones = 5.
- Load clamp: clrn = 0, loadn = 0, data = 9 → ones = 5. Data = 0 → ones = 0, zero = 1.
- Load over enable: ones = 1, en = 1, loadn = 0, data = 3 → ones = 3 (not 0). tc stays 0 in that cycle.
- tc combinational: hold ones = 0 and toggle en mid-cycle → tc follows en immediately with no clock edge.
